// File: rtl/vga_pkg.sv
// +--------------------------------------------------------------------------+
// | vga_pkg : default VGA 640x480@60 timing constants and controller states  |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

package vga_pkg;

  localparam int unsigned CNT_W = 16;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } vga_state_e;

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// +--------------------------------------------------------------------------+
// | vga_axis_counter : enabled modulo-TOTAL counter with wrap pulse          |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL = H_TOTAL_DEF,
  parameter int unsigned W     = CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] next_o,
  output logic         wrap_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    wrap_o  = en_i && (count_q == W'(TOTAL - 1));
    count_d = count_q;
    if (rst_i || wrap_o) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    count_q <= count_d;
  end

  assign count_o = count_q;
  assign next_o  = count_d;

endmodule

`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
// +--------------------------------------------------------------------------+
// | vga_timing_ctrl : VGA sync/blanking generator with run/drain control.    |
// | Optional frame interrupt when VGA_FRAME_IRQ_EN is defined.               |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic             clk_25MHz,
  input  logic             rst,
  input  logic             run,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start,
  output logic             busy
`ifdef VGA_FRAME_IRQ_EN
 ,input  logic             irq_clr,
  output logic             frame_irq
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] C_HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] C_HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] C_VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] C_VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] C_H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] C_V_ACT    = CNT_W'(V_ACTIVE);

  vga_state_e       state_q, state_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             h_en, h_wrap, v_wrap;
  logic             active_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
  logic             line_start_q, line_start_d, frame_start_q, frame_start_d;

  assign h_en = (state_q != ST_IDLE);

  vga_axis_counter #(.TOTAL(H_TOTAL), .W(CNT_W)) u_h_cnt (
    .clk_i  (clk_25MHz),
    .rst_i  (rst),
    .en_i   (h_en),
    .count_o(x_q),
    .next_o (x_d),
    .wrap_o (h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL), .W(CNT_W)) u_v_cnt (
    .clk_i  (clk_25MHz),
    .rst_i  (rst),
    .en_i   (h_wrap),
    .count_o(y_q),
    .next_o (y_d),
    .wrap_o (v_wrap)
  );

  // v_wrap implies h_wrap, so it marks the last pixel of the frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!run) state_d = v_wrap ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (run)         state_d = ST_RUN;
        else if (v_wrap) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) state_d = ST_IDLE;
  end

  // Decode from next-state counters so the registered flags line up with pixel_x/pixel_y.
  always_comb begin
    active_d      = (state_d != ST_IDLE);
    hsync_d       = !(active_d && (x_d >= C_HS_START) && (x_d <= C_HS_END));
    vsync_d       = !(active_d && (y_d >= C_VS_START) && (y_d <= C_VS_END));
    video_on_d    = active_d && (x_d < C_H_ACT) && (y_d < C_V_ACT);
    line_start_d  = active_d && (x_d == '0);
    frame_start_d = line_start_d && (y_d == '0);
  end

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign busy        = (state_q != ST_IDLE);

`ifdef VGA_FRAME_IRQ_EN
  logic frame_irq_q;
  logic irq_set;

  assign irq_set = h_en && (x_q == C_H_ACT - 1'b1) && (y_q == C_V_ACT - 1'b1);

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      frame_irq_q <= 1'b0;
    end else begin
      frame_irq_q <= irq_set || (frame_irq_q && !irq_clr);
    end
  end

  assign frame_irq = frame_irq_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_vga_timing_ctrl : self-checking bench on a reduced 25x15 raster       |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_vga_timing_ctrl;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        hs;
    logic        vs;
    logic        vo;
    logic        ls;
    logic        fs;
    logic        bz;
    logic        irq;
  } obs_t;

  typedef struct {
    logic rst;
    logic run;
    obs_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        hsync, vsync, video_on, line_start, frame_start, busy;
  logic [15:0] pixel_x, pixel_y;
`ifdef VGA_FRAME_IRQ_EN
  logic        irq_clr = 1'b0;
  logic        frame_irq;
`endif

  always #5 clk = ~clk;

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
`ifdef VGA_FRAME_IRQ_EN
    .irq_clr    (irq_clr),
    .frame_irq  (frame_irq),
`endif
    .clk_25MHz  (clk),
    .rst        (rst),
    .run        (run),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .line_start (line_start),
    .frame_start(frame_start),
    .busy       (busy)
  );

  int   checks = 0;
  int   errors = 0;
  obs_t sb_q[$];
  bit   meas_en = 1'b0;

  // Reference model: what the DUT should show after the next clock edge.
  int m_bz = 0, m_x = 0, m_y = 0;
  bit m_irq = 1'b0;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s @%0t: actual %0d, required %0d", name, $time, act, req);
    end
  endtask

  function automatic obs_t mk(input int x, input int y, input bit hs, input bit vs,
                              input bit vo, input bit ls, input bit fs, input bit bz);
    obs_t o;
    o = '{x: 16'(x), y: 16'(y), hs: hs, vs: vs, vo: vo, ls: ls, fs: fs, bz: bz, irq: 1'b0};
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.x   = 16'(m_x);
    o.y   = 16'(m_y);
    o.hs  = !(m_bz != 0 && m_x >= HA + HF && m_x <= HA + HF + HS - 1);
    o.vs  = !(m_bz != 0 && m_y >= VA + VF && m_y <= VA + VF + VS - 1);
    o.vo  = (m_bz != 0) && m_x < HA && m_y < VA;
    o.ls  = (m_bz != 0) && m_x == 0;
    o.fs  = (m_bz != 0) && m_x == 0 && m_y == 0;
    o.bz  = (m_bz != 0);
`ifdef VGA_FRAME_IRQ_EN
    o.irq = m_irq;
`else
    o.irq = 1'b0;
`endif
    return o;
  endfunction

  task automatic model_step(input bit r, input bit rn, input bit clr);
    bit last, set;
    if (r) begin
      m_bz = 0; m_x = 0; m_y = 0; m_irq = 1'b0;
    end else begin
      set   = (m_bz != 0) && m_x == HA - 1 && m_y == VA - 1;
      m_irq = set || (m_irq && !clr);
      if (m_bz == 0) begin
        if (rn) m_bz = 1;
      end else begin
        last = (m_x == HT - 1) && (m_y == VT - 1);
        if (m_x == HT - 1) begin
          m_x = 0;
          m_y = (m_y == VT - 1) ? 0 : m_y + 1;
        end else begin
          m_x = m_x + 1;
        end
        if (last && !rn) m_bz = 0;
      end
    end
  endtask

  task automatic apply(input bit r, input bit rn, input bit clr);
    @(negedge clk);
    #1;
    rst = r;
    run = rn;
`ifdef VGA_FRAME_IRQ_EN
    irq_clr = clr;
`endif
    model_step(r, rn, clr);
  endtask

  task automatic drive(input bit r, input bit rn, input bit clr);
    apply(r, rn, clr);
    sb_q.push_back(model_obs());
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input int tx, input int ty, input bit rn, input string tag);
    int n;
    n = 0;
    do begin
      drive(1'b0, rn, 1'b0);
      n++;
    end while (!(m_x == tx && m_y == ty) && n < 2 * FRAME);
    if (!(m_x == tx && m_y == ty)) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: actual (%0d,%0d), required (%0d,%0d)", tag, m_x, m_y, tx, ty);
    end
  endtask

  task automatic drain_to_idle(input string tag);
    int n;
    n = 0;
    while (m_bz != 0 && n < 2 * FRAME) begin
      drive(1'b0, 1'b0, 1'b0);
      n++;
    end
    if (m_bz != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: actual busy=%0d, required busy=0", tag, m_bz);
    end
  endtask

  // Scoreboard comparison plus raster measurements.
  obs_t act_o, exp_o;
  int   cyc, last_fs, ls_cnt, vo_cnt, hs_low, vs_lines;
  bit   seen_fs, hs_valid, vs_valid, prev_hs, prev_vs;

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_o = sb_q.pop_front();
      act_o.x = pixel_x;  act_o.y = pixel_y;
      act_o.hs = hsync;   act_o.vs = vsync;    act_o.vo = video_on;
      act_o.ls = line_start; act_o.fs = frame_start; act_o.bz = busy;
`ifdef VGA_FRAME_IRQ_EN
      act_o.irq = frame_irq;
`else
      act_o.irq = 1'b0;
`endif
      checks++;
      if (act_o !== exp_o) begin
        errors++;
        $display("FAIL scoreboard @%0t: actual x=%0d y=%0d hs,vs,vo,ls,fs,busy,irq=%b, required x=%0d y=%0d hs,vs,vo,ls,fs,busy,irq=%b",
                 $time, act_o.x, act_o.y,
                 {act_o.hs, act_o.vs, act_o.vo, act_o.ls, act_o.fs, act_o.bz, act_o.irq},
                 exp_o.x, exp_o.y,
                 {exp_o.hs, exp_o.vs, exp_o.vo, exp_o.ls, exp_o.fs, exp_o.bz, exp_o.irq});
      end
    end

    if (!meas_en) begin
      cyc = 0; seen_fs = 1'b0; hs_valid = 1'b0; vs_valid = 1'b0;
      prev_hs = 1'b1; prev_vs = 1'b1; ls_cnt = 0; vo_cnt = 0; hs_low = 0; vs_lines = 0;
    end else begin
      cyc++;
      if (frame_start) begin
        if (seen_fs) begin
          chk(cyc - last_fs == FRAME, "frame_period", cyc - last_fs, FRAME);
          chk(ls_cnt == VT, "lines_per_frame", ls_cnt, VT);
          chk(vo_cnt == HA * VA, "video_on_per_frame", vo_cnt, HA * VA);
        end
        seen_fs = 1'b1; last_fs = cyc; ls_cnt = 0; vo_cnt = 0;
      end
      if (line_start) ls_cnt++;
      if (video_on)   vo_cnt++;

      if (!hsync && prev_hs) begin
        chk(int'(pixel_x) == HA + HF, "hsync_start_x", int'(pixel_x), HA + HF);
        hs_low = 0; hs_valid = 1'b1;
      end
      if (!hsync) hs_low++;
      if (hsync && !prev_hs && hs_valid) chk(hs_low == HS, "hsync_width", hs_low, HS);

      if (!vsync && prev_vs) begin
        chk(int'(pixel_y) == VA + VF, "vsync_start_y", int'(pixel_y), VA + VF);
        vs_lines = 0; vs_valid = 1'b1;
      end
      if (!vsync && line_start) vs_lines++;
      if (vsync && !prev_vs && vs_valid) chk(vs_lines == VS, "vsync_lines", vs_lines, VS);

      prev_hs = hsync;
      prev_vs = vsync;
    end
  end

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b1, 1'b1, mk(0, 0, 1, 1, 0, 0, 0, 0)};
    vecs[1] = '{1'b1, 1'b0, mk(0, 0, 1, 1, 0, 0, 0, 0)};
    vecs[2] = '{1'b0, 1'b0, mk(0, 0, 1, 1, 0, 0, 0, 0)};
    vecs[3] = '{1'b0, 1'b1, mk(0, 0, 1, 1, 1, 1, 1, 1)};
    vecs[4] = '{1'b0, 1'b1, mk(1, 0, 1, 1, 1, 0, 0, 1)};
    vecs[5] = '{1'b0, 1'b0, mk(2, 0, 1, 1, 1, 0, 0, 1)};
    vecs[6] = '{1'b0, 1'b1, mk(3, 0, 1, 1, 1, 0, 0, 1)};

    for (int i = 0; i < 7; i++) begin
      apply(vecs[i].rst, vecs[i].run, 1'b0);
      sb_q.push_back(vecs[i].exp);
    end

    // Two full frames with raster measurements.
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    meas_en = 1'b1;
    for (int i = 0; i < 2 * FRAME + 3; i++) drive(1'b0, 1'b1, 1'b0);
    meas_en = 1'b0;

    // Drop run mid-frame: the frame completes, then idle.
    drive(1'b1, 1'b0, 1'b0);
    run_until(5, 4, 1'b1, "reach_drop_point");
    drain_to_idle("drain");
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0);
    settle();
    chk(busy == 1'b0, "idle_busy", int'(busy), 0);
    chk(hsync == 1'b1 && vsync == 1'b1, "idle_syncs", int'({hsync, vsync}), 3);

    // Drop run then raise it before frame end: scan-out never stops.
    run_until(5, 4, 1'b1, "reach_drop_point2");
    run_until(3, 9, 1'b0, "reach_raise_point");
    for (int i = 0; i < FRAME; i++) drive(1'b0, 1'b1, 1'b0);
    settle();
    chk(busy == 1'b1, "resume_no_stop", int'(busy), 1);

    // Reset mid-frame with run held high.
    drive(1'b1, 1'b0, 1'b0);
    run_until(12, 7, 1'b1, "reach_reset_point");
    drive(1'b1, 1'b1, 1'b0);
    settle();
    chk(pixel_x == 16'd0 && pixel_y == 16'd0 && busy == 1'b0, "reset_mid_frame",
        int'(pixel_x) + int'(pixel_y) + int'(busy), 0);
    drive(1'b0, 1'b1, 1'b0);
    settle();
    chk(frame_start == 1'b1 && busy == 1'b1, "restart_at_origin",
        int'({frame_start, busy}), 3);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0);

`ifdef VGA_FRAME_IRQ_EN
    drive(1'b1, 1'b0, 1'b0);
    run_until(HA - 1, VA - 1, 1'b1, "reach_last_visible");
    settle();
    chk(frame_irq == 1'b0, "irq_before_set", int'(frame_irq), 0);
    drive(1'b0, 1'b1, 1'b0);
    settle();
    chk(frame_irq == 1'b1, "irq_rise", int'(frame_irq), 1);
    drive(1'b0, 1'b1, 1'b1);
    settle();
    chk(frame_irq == 1'b0, "irq_clear", int'(frame_irq), 0);
    run_until(HA - 1, VA - 1, 1'b1, "reach_last_visible2");
    drive(1'b0, 1'b1, 1'b1);
    settle();
    chk(frame_irq == 1'b1, "irq_set_wins", int'(frame_irq), 1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0);
`endif

    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    chk(sb_q.size() == 0, "scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
